stack_mem_unit: RTL and testbench
=================================

Name: stack_mem_unit

Overview:
- Datapath consumer of the stack and memory control signals produced by the control signal generator of the multi-cycle AVR-style core.
- Owns the stack pointer (SP) and drives the data-memory bus address, read strobe and write strobe.
- Captures loaded bytes for writeback.
- Serialises the two-byte return address for RCALL (two writes) and reassembles it for RET (two reads), using cycle_count to tell the two MEM cycles apart.

Parameters:
- DATA_WIDTH, 8, data-memory word and register width.
- ADDR_WIDTH, 16, data-memory address and SP width.
- PC_WIDTH, 16, program counter width; must satisfy PC_WIDTH <= 2*DATA_WIDTH.
- SP_RESET, 16'h00FF, SP value after reset (top of RAM).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stack_preinc  input  1  CONTROL_STACK_PREINC: SP <= SP+1 at end of this cycle.
- stack_postdec  input  1  CONTROL_STACK_POSTDEC: SP <= SP-1 at end of this cycle.
- mem_read  input  1  CONTROL_MEM_READ.
- mem_write  input  1  CONTROL_MEM_WRITE.
- cycle_count  input  1  MEM sub-cycle index (0 or 1).
- use_stack  input  1  1 = address from SP; 0 = address from indirect_addr.
- is_call  input  1  current instruction is RCALL.
- is_ret  input  1  current instruction is RET.
- indirect_addr  input  ADDR_WIDTH  X/Y/Z pointer or direct address for non-stack accesses.
- wr_data  input  DATA_WIDTH  register (Rr) value for store/PUSH.
- pc_in  input  PC_WIDTH  return address to push on RCALL.
- bus_data_in  input  DATA_WIDTH  read data from memory (asynchronous read).
- bus_addr  output  ADDR_WIDTH  memory address.
- bus_data_out  output  DATA_WIDTH  memory write data.
- bus_re  output  1  read strobe.
- bus_we  output  1  write strobe.
- rd_data  output  DATA_WIDTH  last loaded byte, registered, for WB.
- ret_pc  output  PC_WIDTH  reassembled return address.
- ret_pc_valid  output  1  one-cycle pulse when ret_pc has been updated.
- sp  output  ADDR_WIDTH  current SP.
- stack_fault  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, wins over all inputs): sp=SP_RESET, rd_data=0, ret_pc=0, ret_pc_valid=0, stack_fault=0.
- Address and strobes are combinational in the same cycle:
  - bus_addr = use_stack ? sp : indirect_addr, where sp is the registered value, before any update this cycle.
  - bus_re = mem_read & ~mem_write.
  - bus_we = mem_write & ~mem_read.
- Write data (bus_data_out):
  - is_call & cycle_count=0: PC low byte, pc_in[DATA_WIDTH-1:0].
  - is_call & cycle_count=1: PC high byte, upper bits zero-extended to DATA_WIDTH.
  - Otherwise: wr_data.
- SP update at the clock edge:
  - stack_preinc only: sp+1.
  - stack_postdec only: sp-1.
  - Both asserted: sp is held and stack_fault is set.
  - Arithmetic is modulo 2^ADDR_WIDTH.
  - Wrap-around (preinc at all-ones, or postdec at 0) still updates SP and sets stack_fault.
- Resulting access orders:
  - PUSH: write at SP, then decrement.
  - POP: increment in EX, then read at the new SP in MEM.
  - RCALL: low byte at SP, high byte at SP-1; SP ends 2 lower.
  - RET: increment in EX; MEM cc0 reads the high byte at old SP+1; MEM cc1 reads the low byte at old SP+2; SP ends 2 higher.
- Read capture: rd_data <= bus_data_in on every edge where bus_re=1.
- RET reassembly:
  - Edge with bus_re & is_ret & cycle_count=0: latch the high byte into a holding register.
  - Edge with bus_re & is_ret & cycle_count=1: ret_pc <= {high, bus_data_in} truncated to PC_WIDTH, and ret_pc_valid=1 for exactly the next cycle.
  - A cc1 read without a preceding cc0 read in the same instruction uses the stale holding register; no fault is raised.
- Illegal strobe combination: mem_read & mem_write together drive neither strobe and set stack_fault.
- stack_fault clears only on reset.
- Reset mid-RET, between cc0 and cc1: the holding register clears, and ret_pc_valid is not asserted for the aborted instruction.

Test Plan:
- Reset with sp=0x00FF; PUSH with wr_data=0xA5 → bus_we=1, bus_addr=0x00FF, bus_data_out=0xA5; sp=0x00FE next cycle.
- POP after that PUSH: EX preinc → sp=0x00FF; MEM read with bus_data_in=0xA5 → bus_addr=0x00FF, rd_data=0xA5.
- RCALL with pc_in=0x0123, sp=0x00FF → cc0 writes 0x23 at 0x00FF, cc1 writes 0x01 at 0x00FE, sp=0x00FD.
- RET from sp=0x00FD with memory returning 0x01 then 0x23 → reads at 0x00FE then 0x00FF; ret_pc=0x0123; ret_pc_valid high for exactly 1 cycle; sp=0x00FF.
- sp=0x0000 with postdec → sp=0xFFFF, stack_fault=1 and stays 1; preinc and postdec together → sp unchanged, fault set.
- Reset asserted between RET cc0 and cc1 → sp=0x00FF, ret_pc=0, ret_pc_valid stays 0.

Source files
------------

// File: rtl/stack_mem_unit.sv
// Stack and data-memory access unit for the multi-cycle AVR-style core.
// Owns the stack pointer and drives the data-memory bus. It also splits the
// RCALL return address into two byte writes and rebuilds the RET return
// address from two byte reads.
module stack_mem_unit #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    PC_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = 16'h00FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stack_preinc,
  input  logic                  stack_postdec,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  cycle_count,
  input  logic                  use_stack,
  input  logic                  is_call,
  input  logic                  is_ret,
  input  logic [ADDR_WIDTH-1:0] indirect_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_re,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [PC_WIDTH-1:0]   ret_pc,
  output logic                  ret_pc_valid,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  stack_fault
);

  localparam logic [ADDR_WIDTH-1:0] SP_ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SP_ZERO     = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] SP_ALL_ONES = {ADDR_WIDTH{1'b1}};

  // Architectural state
  logic [ADDR_WIDTH-1:0] sp_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [PC_WIDTH-1:0]   ret_pc_r;
  logic                  ret_pc_valid_r;
  logic                  stack_fault_r;
  // High byte of the return address, held between the two RET reads
  logic [DATA_WIDTH-1:0] ret_hi_r;

  // Combinational helpers
  logic [2*DATA_WIDTH-1:0] pc_ext_s;
  logic                    bus_re_s;
  logic                    bus_we_s;
  logic [DATA_WIDTH-1:0]   bus_data_out_s;
  logic [ADDR_WIDTH-1:0]   sp_next_s;
  logic                    sp_fault_s;
  logic                    strobe_fault_s;

  // The return address is zero-extended to two bytes, so the high byte is
  // always a full DATA_WIDTH slice even when PC_WIDTH is narrower.
  assign pc_ext_s = (2*DATA_WIDTH)'(pc_in);

  // A simultaneous read and write is illegal: drive neither strobe.
  assign bus_re_s       = mem_read & ~mem_write;
  assign bus_we_s       = mem_write & ~mem_read;
  assign strobe_fault_s = mem_read & mem_write;

  // Select write data: RCALL pushes PC low byte first, then the high byte
  always_comb begin
    bus_data_out_s = wr_data;
    if (is_call) begin
      if (cycle_count) begin
        bus_data_out_s = pc_ext_s[2*DATA_WIDTH-1:DATA_WIDTH];
      end else begin
        bus_data_out_s = pc_ext_s[DATA_WIDTH-1:0];
      end
    end else begin
      bus_data_out_s = wr_data;
    end
  end

  // Next stack pointer. Wrap-around and conflicting requests raise the fault
  always_comb begin
    sp_next_s  = sp_r;
    sp_fault_s = 1'b0;
    case ({stack_preinc, stack_postdec})
      2'b10: begin
        sp_next_s  = sp_r + SP_ONE;
        sp_fault_s = (sp_r == SP_ALL_ONES);
      end
      2'b01: begin
        sp_next_s  = sp_r - SP_ONE;
        sp_fault_s = (sp_r == SP_ZERO);
      end
      2'b11: begin
        sp_next_s  = sp_r;
        sp_fault_s = 1'b1;
      end
      default: begin
        sp_next_s  = sp_r;
        sp_fault_s = 1'b0;
      end
    endcase
  end

  // Register SP, the loaded byte, RET reassembly and the sticky fault
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r           <= SP_RESET;
      rd_data_r      <= {DATA_WIDTH{1'b0}};
      ret_pc_r       <= {PC_WIDTH{1'b0}};
      ret_pc_valid_r <= 1'b0;
      stack_fault_r  <= 1'b0;
      ret_hi_r       <= {DATA_WIDTH{1'b0}};
    end else begin
      sp_r           <= sp_next_s;
      ret_pc_valid_r <= 1'b0;
      stack_fault_r  <= stack_fault_r | sp_fault_s | strobe_fault_s;
      if (bus_re_s) begin
        rd_data_r <= bus_data_in;
      end
      if (bus_re_s && is_ret) begin
        if (cycle_count) begin
          ret_pc_r       <= PC_WIDTH'({ret_hi_r, bus_data_in});
          ret_pc_valid_r <= 1'b1;
        end else begin
          ret_hi_r <= bus_data_in;
        end
      end
    end
  end

  // The address uses the SP value held before this cycle's update.
  assign bus_addr     = use_stack ? sp_r : indirect_addr;
  assign bus_data_out = bus_data_out_s;
  assign bus_re       = bus_re_s;
  assign bus_we       = bus_we_s;
  assign rd_data      = rd_data_r;
  assign ret_pc       = ret_pc_r;
  assign ret_pc_valid = ret_pc_valid_r;
  assign sp           = sp_r;
  assign stack_fault  = stack_fault_r;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Directed self-checking bench for stack_mem_unit.
module tb_stack_mem_unit;

  logic        clk;
  logic        reset;
  logic        stack_preinc;
  logic        stack_postdec;
  logic        mem_read;
  logic        mem_write;
  logic        cycle_count;
  logic        use_stack;
  logic        is_call;
  logic        is_ret;
  logic [15:0] indirect_addr;
  logic [7:0]  wr_data;
  logic [15:0] pc_in;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  rd_data;
  logic [15:0] ret_pc;
  logic        ret_pc_valid;
  logic [15:0] sp;
  logic        stack_fault;

  int pass_cnt;
  int total_cnt;

  stack_mem_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stack_preinc  (stack_preinc),
    .stack_postdec (stack_postdec),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .cycle_count   (cycle_count),
    .use_stack     (use_stack),
    .is_call       (is_call),
    .is_ret        (is_ret),
    .indirect_addr (indirect_addr),
    .wr_data       (wr_data),
    .pc_in         (pc_in),
    .bus_data_in   (bus_data_in),
    .bus_addr      (bus_addr),
    .bus_data_out  (bus_data_out),
    .bus_re        (bus_re),
    .bus_we        (bus_we),
    .rd_data       (rd_data),
    .ret_pc        (ret_pc),
    .ret_pc_valid  (ret_pc_valid),
    .sp            (sp),
    .stack_fault   (stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stack_preinc  = 1'b0;
    stack_postdec = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    cycle_count   = 1'b0;
    use_stack     = 1'b0;
    is_call       = 1'b0;
    is_ret        = 1'b0;
    indirect_addr = 16'h0000;
    wr_data       = 8'h00;
    pc_in         = 16'h0000;
    bus_data_in   = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    stack_postdec = 1'b1;
    mem_read = 1'b1;
    bus_data_in = 8'h77;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL reset_sp: got %h want 00ff", sp); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else pass_cnt++;
    total_cnt++; if (ret_pc !== 16'h0000) $display("FAIL reset_ret_pc: got %h want 0000", ret_pc); else pass_cnt++;
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ret_pc_valid); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", stack_fault); else pass_cnt++;
  endtask

  task automatic test_push();
    idle();
    use_stack = 1'b1; mem_write = 1'b1; stack_postdec = 1'b1; wr_data = 8'hA5;
    #1;
    total_cnt++; if (bus_we !== 1'b1) $display("FAIL push_we: got %b want 1", bus_we); else pass_cnt++;
    total_cnt++; if (bus_re !== 1'b0) $display("FAIL push_re: got %b want 0", bus_re); else pass_cnt++;
    total_cnt++; if (bus_addr !== 16'h00FF) $display("FAIL push_addr: got %h want 00ff", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_data_out !== 8'hA5) $display("FAIL push_data: got %h want a5", bus_data_out); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (sp !== 16'h00FE) $display("FAIL push_sp: got %h want 00fe", sp); else pass_cnt++;
  endtask

  task automatic test_pop();
    idle();
    stack_preinc = 1'b1;
    tick();
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL pop_ex_sp: got %h want 00ff", sp); else pass_cnt++;
    idle();
    use_stack = 1'b1; mem_read = 1'b1; bus_data_in = 8'hA5;
    #1;
    total_cnt++; if (bus_addr !== 16'h00FF) $display("FAIL pop_addr: got %h want 00ff", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_re !== 1'b1) $display("FAIL pop_re: got %b want 1", bus_re); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (rd_data !== 8'hA5) $display("FAIL pop_rd_data: got %h want a5", rd_data); else pass_cnt++;
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL pop_sp: got %h want 00ff", sp); else pass_cnt++;
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL pop_no_valid: got %b want 0", ret_pc_valid); else pass_cnt++;
  endtask

  task automatic test_rcall();
    idle();
    is_call = 1'b1; mem_write = 1'b1; use_stack = 1'b1; stack_postdec = 1'b1;
    pc_in = 16'h0123; wr_data = 8'hEE; cycle_count = 1'b0;
    #1;
    total_cnt++; if (bus_addr !== 16'h00FF) $display("FAIL rcall_cc0_addr: got %h want 00ff", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_data_out !== 8'h23) $display("FAIL rcall_cc0_data: got %h want 23", bus_data_out); else pass_cnt++;
    tick();
    cycle_count = 1'b1;
    #1;
    total_cnt++; if (bus_addr !== 16'h00FE) $display("FAIL rcall_cc1_addr: got %h want 00fe", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_data_out !== 8'h01) $display("FAIL rcall_cc1_data: got %h want 01", bus_data_out); else pass_cnt++;
    total_cnt++; if (bus_we !== 1'b1) $display("FAIL rcall_cc1_we: got %b want 1", bus_we); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (sp !== 16'h00FD) $display("FAIL rcall_sp: got %h want 00fd", sp); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b0) $display("FAIL rcall_fault: got %b want 0", stack_fault); else pass_cnt++;
  endtask

  task automatic test_ret();
    idle();
    stack_preinc = 1'b1;
    tick();
    idle();
    is_ret = 1'b1; mem_read = 1'b1; use_stack = 1'b1; stack_preinc = 1'b1;
    cycle_count = 1'b0; bus_data_in = 8'h01;
    #1;
    total_cnt++; if (bus_addr !== 16'h00FE) $display("FAIL ret_cc0_addr: got %h want 00fe", bus_addr); else pass_cnt++;
    tick();
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL ret_cc0_valid: got %b want 0", ret_pc_valid); else pass_cnt++;
    stack_preinc = 1'b0; cycle_count = 1'b1; bus_data_in = 8'h23;
    #1;
    total_cnt++; if (bus_addr !== 16'h00FF) $display("FAIL ret_cc1_addr: got %h want 00ff", bus_addr); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (ret_pc !== 16'h0123) $display("FAIL ret_pc: got %h want 0123", ret_pc); else pass_cnt++;
    total_cnt++; if (ret_pc_valid !== 1'b1) $display("FAIL ret_valid_pulse: got %b want 1", ret_pc_valid); else pass_cnt++;
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL ret_sp: got %h want 00ff", sp); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h23) $display("FAIL ret_rd_data: got %h want 23", rd_data); else pass_cnt++;
    tick();
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL ret_valid_drop: got %b want 0", ret_pc_valid); else pass_cnt++;
    total_cnt++; if (ret_pc !== 16'h0123) $display("FAIL ret_pc_hold: got %h want 0123", ret_pc); else pass_cnt++;
  endtask

  task automatic test_indirect();
    idle();
    indirect_addr = 16'h1234; mem_write = 1'b1; wr_data = 8'h5A;
    #1;
    total_cnt++; if (bus_addr !== 16'h1234) $display("FAIL ind_wr_addr: got %h want 1234", bus_addr); else pass_cnt++;
    total_cnt++; if (bus_data_out !== 8'h5A) $display("FAIL ind_wr_data: got %h want 5a", bus_data_out); else pass_cnt++;
    tick();
    idle();
    indirect_addr = 16'hBEEF; mem_read = 1'b1; bus_data_in = 8'h3C;
    #1;
    total_cnt++; if (bus_addr !== 16'hBEEF) $display("FAIL ind_rd_addr: got %h want beef", bus_addr); else pass_cnt++;
    tick();
    idle();
    bus_data_in = 8'h99;
    total_cnt++; if (rd_data !== 8'h3C) $display("FAIL ind_rd_data: got %h want 3c", rd_data); else pass_cnt++;
    tick();
    total_cnt++; if (rd_data !== 8'h3C) $display("FAIL rd_data_hold: got %h want 3c", rd_data); else pass_cnt++;
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL ind_sp: got %h want 00ff", sp); else pass_cnt++;
  endtask

  task automatic test_fault();
    do_reset();
    stack_postdec = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    total_cnt++; if (sp !== 16'h0000) $display("FAIL dec_to_zero_sp: got %h want 0000", sp); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b0) $display("FAIL dec_to_zero_fault: got %b want 0", stack_fault); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (sp !== 16'hFFFF) $display("FAIL wrap_sp: got %h want ffff", sp); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b1) $display("FAIL wrap_fault: got %b want 1", stack_fault); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (stack_fault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", stack_fault); else pass_cnt++;
    do_reset();
    stack_preinc = 1'b1; stack_postdec = 1'b1;
    tick();
    idle();
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL both_sp: got %h want 00ff", sp); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b1) $display("FAIL both_fault: got %b want 1", stack_fault); else pass_cnt++;
    do_reset();
    mem_read = 1'b1; mem_write = 1'b1; bus_data_in = 8'h66;
    #1;
    total_cnt++; if (bus_re !== 1'b0) $display("FAIL illegal_re: got %b want 0", bus_re); else pass_cnt++;
    total_cnt++; if (bus_we !== 1'b0) $display("FAIL illegal_we: got %b want 0", bus_we); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (stack_fault !== 1'b1) $display("FAIL illegal_fault: got %b want 1", stack_fault); else pass_cnt++;
    total_cnt++; if (rd_data !== 8'h00) $display("FAIL illegal_no_capture: got %h want 00", rd_data); else pass_cnt++;
  endtask

  task automatic test_ret_reset();
    do_reset();
    is_ret = 1'b1; mem_read = 1'b1; use_stack = 1'b1; stack_preinc = 1'b1;
    cycle_count = 1'b0; bus_data_in = 8'h01;
    tick();
    reset = 1'b1; stack_preinc = 1'b0; cycle_count = 1'b1; bus_data_in = 8'h23;
    tick();
    reset = 1'b0;
    idle();
    total_cnt++; if (sp !== 16'h00FF) $display("FAIL ret_rst_sp: got %h want 00ff", sp); else pass_cnt++;
    total_cnt++; if (ret_pc !== 16'h0000) $display("FAIL ret_rst_pc: got %h want 0000", ret_pc); else pass_cnt++;
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL ret_rst_valid: got %b want 0", ret_pc_valid); else pass_cnt++;
    tick();
    total_cnt++; if (ret_pc_valid !== 1'b0) $display("FAIL ret_rst_valid_after: got %b want 0", ret_pc_valid); else pass_cnt++;
    // A lone cc1 read now uses the cleared holding register.
    is_ret = 1'b1; mem_read = 1'b1; use_stack = 1'b1; cycle_count = 1'b1; bus_data_in = 8'h45;
    tick();
    idle();
    total_cnt++; if (ret_pc !== 16'h0045) $display("FAIL stale_hold_pc: got %h want 0045", ret_pc); else pass_cnt++;
    total_cnt++; if (ret_pc_valid !== 1'b1) $display("FAIL stale_hold_valid: got %b want 1", ret_pc_valid); else pass_cnt++;
    total_cnt++; if (stack_fault !== 1'b0) $display("FAIL stale_hold_fault: got %b want 0", stack_fault); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_push();
    test_pop();
    test_rcall();
    test_ret();
    test_indirect();
    test_fault();
    test_ret_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
